// File: rtl/code_length_checker.sv
// Keypad frame length checker: frames digit entry between terminator keys,
// counts digits and flags legal user-code / multi-phase program-code lengths.
module code_length_checker #(
  parameter int unsigned KEY_W       = 4,
  parameter int unsigned CNT_W       = 4,
  parameter int unsigned UC_MIN      = 4,
  parameter int unsigned UC_MAX      = 6,
  parameter int unsigned PC_LEN      = 6,
  parameter int unsigned PROG_PHASES = 3,
  parameter int unsigned KEY_LOCK    = 9,
  parameter int unsigned KEY_PROG    = 8,
  parameter int unsigned KEY_CLEAR   = 7
) (
  input  logic             hwclk,
  input  logic             rst_n,
  input  logic             key_valid,
  input  logic [KEY_W-1:0] key_code,
  input  logic             read_input,
  input  logic             input_wrong,
  output logic             valid_uc,
  output logic             valid_pc,
  output logic             done,
  output logic             busy,
  output logic [1:0]       phase,
  output logic [CNT_W-1:0] digit_count,
  output logic             overflow
);

  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_NEAR   = CNT_MAX - CNT_W'(1);
  localparam logic [CNT_W-1:0] UC_MIN_C   = CNT_W'(UC_MIN);
  localparam logic [CNT_W-1:0] UC_MAX_C   = CNT_W'(UC_MAX);
  localparam logic [CNT_W-1:0] PC_LEN_C   = CNT_W'(PC_LEN);
  localparam logic [1:0]       LAST_PHASE = 2'(PROG_PHASES - 1);
  localparam logic [KEY_W-1:0] K_LOCK     = KEY_W'(KEY_LOCK);
  localparam logic [KEY_W-1:0] K_PROG     = KEY_W'(KEY_PROG);
  localparam logic [KEY_W-1:0] K_CLEAR    = KEY_W'(KEY_CLEAR);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOCK = 2'd1,
    ST_PROG = 2'd2
  } state_t;

  state_t state;
  logic   phase_ok;

  logic accept_c;
  logic phase_len_ok_c;
  logic uc_len_ok_c;

  // Key acceptance and length qualification of the frame being closed
  always_comb begin
    accept_c       = key_valid & read_input;
    phase_len_ok_c = !overflow && (digit_count == PC_LEN_C);
    uc_len_ok_c    = !overflow && (digit_count >= UC_MIN_C) && (digit_count <= UC_MAX_C);
  end

  // Framing FSM with registered outputs; abort takes priority over any key
  always_ff @(posedge hwclk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      busy        <= 1'b0;
      valid_uc    <= 1'b0;
      valid_pc    <= 1'b0;
      done        <= 1'b0;
      phase       <= 2'd0;
      phase_ok    <= 1'b0;
      digit_count <= '0;
      overflow    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (input_wrong || (accept_c && key_code == K_CLEAR)) begin
        state       <= ST_IDLE;
        busy        <= 1'b0;
        valid_uc    <= 1'b0;
        valid_pc    <= 1'b0;
        phase       <= 2'd0;
        phase_ok    <= 1'b0;
        digit_count <= '0;
        overflow    <= 1'b0;
      end else if (accept_c) begin
        case (state)
          ST_IDLE: begin
            if (key_code == K_LOCK || key_code == K_PROG) begin
              state       <= (key_code == K_LOCK) ? ST_LOCK : ST_PROG;
              busy        <= 1'b1;
              phase       <= 2'd0;
              phase_ok    <= 1'b1;
              digit_count <= '0;
              overflow    <= 1'b0;
              valid_uc    <= 1'b0;
              valid_pc    <= 1'b0;
            end
          end
          ST_LOCK: begin
            if (key_code == K_LOCK) begin
              valid_uc <= uc_len_ok_c;
              done     <= 1'b1;
              state    <= ST_IDLE;
              busy     <= 1'b0;
            end else begin
              if (digit_count != CNT_MAX) digit_count <= digit_count + CNT_W'(1);
              if (digit_count >= CNT_NEAR) overflow <= 1'b1;
            end
          end
          ST_PROG: begin
            if (key_code == K_PROG) begin
              phase_ok <= phase_ok & phase_len_ok_c;
              if (phase == LAST_PHASE) begin
                valid_pc <= phase_ok & phase_len_ok_c;
                done     <= 1'b1;
                state    <= ST_IDLE;
                busy     <= 1'b0;
              end else begin
                phase       <= phase + 2'd1;
                digit_count <= '0;
                overflow    <= 1'b0;
              end
            end else begin
              if (digit_count != CNT_MAX) digit_count <= digit_count + CNT_W'(1);
              if (digit_count >= CNT_NEAR) overflow <= 1'b1;
            end
          end
          default: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
